// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } sweep_state_t;

    localparam int unsigned SETTLE_W   = 8;
    localparam int unsigned SETTLE_MIN = 3;

endpackage

// File: rtl/tts_sync2.sv
// Two-flop synchronizer for the gate-under-test output.
module tts_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector into a gate and assembles its truth-table code.
// Optional self-compare against an expected code: TRUTH_TABLE_SWEEPER_CHECK_EN.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned N_IN          = 3,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      stim,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_code
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    ,
    input  logic [2**N_IN-1:0]   expected_code,
    output logic                 mismatch,
    output logic [2**N_IN-1:0]   mismatch_mask
`endif
);

    localparam int unsigned         CODE_W   = 2**N_IN;
    localparam logic [N_IN-1:0]     STIM_MAX = {N_IN{1'b1}};
    localparam logic [SETTLE_W-1:0] RELOAD   = SETTLE_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > (2**SETTLE_W - 1)) begin : g_bad_settle
        $error("truth_table_sweeper: SETTLE_CYCLES must be in 3..255");
    end

    sweep_state_t          state_q;
    logic [SETTLE_W-1:0]   cnt_q;
    logic [N_IN-1:0]       stim_q;
    logic [CODE_W-1:0]     code_q;
    logic [CODE_W-1:0]     code_upd;
    logic                  busy_q;
    logic                  done_q;
    logic                  dut_sync;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    logic [CODE_W-1:0]     exp_q;
    logic [CODE_W-1:0]     mask_q;
    logic                  mis_q;
`endif

    tts_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dut_out),
        .q_o   (dut_sync)
    );

    // Table with the current vector's sample merged in.
    always_comb begin
        code_upd         = code_q;
        code_upd[stim_q] = dut_sync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stim_q  <= '0;
            code_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
            exp_q   <= '0;
            mask_q  <= '0;
            mis_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SETTLE;
                        stim_q  <= '0;
                        code_q  <= '0;
                        cnt_q   <= RELOAD;
                        busy_q  <= 1'b1;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
                        exp_q   <= expected_code;
                        mask_q  <= '0;
                        mis_q   <= 1'b0;
`endif
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - SETTLE_W'(1);
                    end
                end
                SAMPLE: begin
                    code_q <= code_upd;
                    if (stim_q == STIM_MAX) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
                        mask_q  <= code_upd ^ exp_q;
                        mis_q   <= |(code_upd ^ exp_q);
`endif
                    end else begin
                        stim_q  <= stim_q + N_IN'(1);
                        cnt_q   <= RELOAD;
                        state_q <= SETTLE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign table_code = code_q;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    assign mismatch      = mis_q;
    assign mismatch_mask = mask_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper with behavioural gate models.
`timescale 1ns/1ps
module tb_truth_table_sweeper;

    localparam int unsigned N_IN  = 3;
    localparam int unsigned S     = 4;
    localparam int unsigned CW    = 8;
    localparam int          SWEEP = CW * (S + 1);   // last capture edge, relative to E0

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic [N_IN-1:0] stim;
    logic [CW-1:0]   table_code;
    logic [CW-1:0]   gate_code = 8'hBD;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    logic [CW-1:0]   expected_code = '0;
    logic            mismatch;
    logic [CW-1:0]   mismatch_mask;
`endif

    typedef struct {
        int            done_cyc;
        logic [CW-1:0] code;
        logic          mis;
        logic [CW-1:0] mask;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc       = 0;
    int   e0        = 0;
    bit   track_en  = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural gate: output is the code bit selected by the input vector.
    assign dut_out = gate_code[stim];

    truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stim       (stim),
        .dut_out    (dut_out),
        .busy       (busy),
        .done       (done),
        .table_code (table_code)
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        ,
        .expected_code (expected_code),
        .mismatch      (mismatch),
        .mismatch_mask (mismatch_mask)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_sweep(input int e0v, input logic [CW-1:0] code, input logic [CW-1:0] expc);
        sb.push_back('{e0v + SWEEP, code, (code != expc), code ^ expc});
    endtask

    // Monitor: every done pulse is matched against the oldest expected sweep.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
                chk("table_code", 32'(table_code), 32'(mon_e.code));
                chk("busy_at_done", 32'(busy), 32'd0);
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
                chk("mismatch", 32'(mismatch), 32'(mon_e.mis));
                chk("mismatch_mask", 32'(mismatch_mask), 32'(mon_e.mask));
`endif
            end
        end
    end

    // Vector k is driven for the S+1 cycles following edge E0+k*(S+1).
    always @(negedge clk) begin
        if (rst_n && track_en && cyc >= e0 && cyc <= e0 + SWEEP) begin
            chk("stim_step", 32'(stim), ((cyc - e0) / (S + 1) > 7) ? 32'd7 : 32'((cyc - e0) / (S + 1)));
            chk("busy_level", 32'(busy), (cyc - e0 < SWEEP) ? 32'd1 : 32'd0);
        end
    end

    task automatic sweep(input logic [CW-1:0] g, input logic [CW-1:0] expc, input bit repulse);
        gate_code = g;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        expected_code = expc;
`endif
        @(negedge clk);
        start    = 1'b1;
        e0       = cyc + 1;
        track_en = 1'b1;
        expect_sweep(e0, g, expc);
        @(negedge clk);
        start = 1'b0;
        chk("code_cleared_at_start", 32'(table_code), 32'd0);
        if (repulse) begin
            while (cyc < e0 + 11) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (cyc < e0 + SWEEP + 3) @(negedge clk);
        track_en = 1'b0;
        chk("sweep_completed", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stim", 32'(stim), 32'd0);
        chk("rst_code", 32'(table_code), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0xBD gate; with the check option the expectation is off by bit 0.
        sweep(8'hBD, 8'hBC, 1'b0);
        sweep(8'h00, 8'h00, 1'b0);
        sweep(8'hFF, 8'hFF, 1'b0);
        // A start pulse mid-sweep must be ignored.
        sweep(8'hBD, 8'hBD, 1'b1);

        // Asynchronous reset at E17 discards the partial result.
        gate_code = 8'hBD;
        @(negedge clk);
        start = 1'b1;
        e0    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + 16) @(negedge clk);
        chk("partial_code", 32'(table_code), 32'h05);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_stim", 32'(stim), 32'd0);
        chk("arst_code", 32'(table_code), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sweep(8'hBD, 8'hBD, 1'b0);

        // Held start: DONE, one IDLE cycle, then re-accept, so 42 edges apart.
        gate_code = 8'hBD;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        expected_code = 8'hBD;
`endif
        @(negedge clk);
        start = 1'b1;
        e0    = cyc + 1;
        expect_sweep(e0,      8'hBD, 8'hBD);
        expect_sweep(e0 + 42, 8'hBD, 8'hBD);
        expect_sweep(e0 + 84, 8'hBD, 8'hBD);
        while (cyc < e0 + 85) @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + 84 + SWEEP + 4) @(negedge clk);
        chk("held_start_sweeps", 32'(sb.size()), 32'd0);
        chk("idle_after_held", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
